song_memory_reader: RTL and testbench
=====================================

// Module: song_memory_reader
// PURPOSE
//  Playback side of the MiniPiano record path: reads note entries that the free-mode recorder (write_on) stored in song RAM
//  and replays them as timed note/octave codes for the Buzzer, plus LED and 7-seg note display.
//  Sits between the song RAM read port and the Controller's auto-mode note/octave mux.
// PARAMETERS
//  ADDR_W      6           song RAM address width (max 2**ADDR_W entries)
//  TICK_DIV    12_500_000  clk cycles per duration unit at normal speed (1/8 s at 100 MHz)
//  GAP_CYCLES  1_000_000   silent cycles inserted after every note (articulation), >=1
// PORTS
//  clk          in   1       system clock (100 MHz)
//  sys_rst_n    in   1       asynchronous active-low reset
//  start        in   1       debounced 1-cycle pulse: begin playback from address 0
//  stop         in   1       abort playback (level, sampled every cycle)
//  pause        in   1       hold playback (honoured only with PLAYER_PAUSE_EN)
//  speed_select in   2       00 normal, 01 fast (TICK_DIV/2), 10 slow (TICK_DIV*2), 11 normal
//  song_len     in   ADDR_W  number of valid entries recorded
//  rd_addr      out  ADDR_W  song RAM read address
//  rd_data      in   10      entry {octave[9:8], note[7:4], dur[3:0]}; sync RAM, 1-cycle latency
//  note_out     out  4       0 = silence, 1..7 = do..si (Buzzer code)
//  octave_out   out  2       octave for current note
//  led_out      out  7       one-hot of note_out (bit n-1 for note n), 0 when silent
//  busy         out  1       high from accepted start until return to IDLE
//  done         out  1       1-cycle pulse on normal end of song
// BEHAVIOUR
//  Reset: state IDLE, rd_addr=0, note_out=0, octave_out=0, led_out=0, busy=0, done=0, counters cleared.
//  FSM: IDLE -> FETCH -> WAIT -> LOAD -> PLAY -> GAP -> FETCH ... -> DONE -> IDLE.
//   IDLE : start=1 -> FETCH, rd_addr<=0, busy<=1; song_len==0 -> DONE directly.
//   FETCH: rd_addr stable; -> WAIT.   WAIT: RAM output valid end of cycle; -> LOAD.
//   LOAD : capture rd_data. dur==0 (end marker) -> DONE. Else note_out/octave_out/led_out update next cycle; -> PLAY.
//  Latency: start sampled cycle N -> note_out valid cycle N+4.
//  PLAY: lasts dur*U cycles, U = unit per speed_select; speed_select sampled at each unit boundary.
//   note field 0 or >7 -> rest: note_out=0, led_out=0 for the duration.
//  GAP: note_out=0, led_out=0 for GAP_CYCLES; octave_out held. Then rd_addr+1; if new addr==song_len -> DONE else FETCH.
//  Address: rd_addr increment wraps modulo 2**ADDR_W; song_len==0 with full RAM never read past song_len.
//  DONE: done=1 one cycle, busy=0, outputs silent; -> IDLE.
//  stop=1 in any non-IDLE state: next cycle IDLE, outputs silent, busy=0, NO done pulse. stop has priority over start.
//  start while busy: ignored. start and stop same cycle in IDLE: stays IDLE.
//  Duration counter width: 4-bit dur x unit counter sized for TICK_DIV*2; no overflow at dur=15, slow speed.
//  Async reset mid-playback: all outputs to reset values immediately, no done pulse.
// CONFIGURATION
//  PLAYER_PAUSE_EN defined: pause=1 in PLAY/GAP freezes unit and gap counters, forces note_out=0/led_out=0,
//   keeps rd_addr; pause=0 resumes at frozen count, note restored next cycle. pause ignored in FETCH/WAIT/LOAD (latched, applied in PLAY).
//  Not defined: pause port present but ignored; no freeze logic synthesised.
// TESTING (bench: TICK_DIV=4, GAP_CYCLES=2, speed 00 unless stated)
//  RAM {1,3,2},{2,5,1}, song_len=2, start -> note 3/oct1 for 8 cyc, 2 silent, note 5/oct2 for 4 cyc, 2 silent, done 1 cyc.
//  speed_select=01 then 10 on entry dur=2 -> PLAY 4 cyc then 16 cyc; first note_out exactly 4 cyc after start.
//  Entry dur=0 at addr 1, song_len=5 -> plays addr 0 only, done after its gap; song_len=0 -> done 2 cyc after start, no note.
//  stop mid-PLAY -> next cycle note_out=0, busy=0, done stays 0; start while busy -> rd_addr sequence unchanged.
//  Note field 0 and 9 -> note_out=0, led_out=0 for dur*4 cyc; note 7 -> led_out=7'b1000000.
//  PLAYER_PAUSE_EN: pause 10 cyc mid-note -> silent 10 cyc, total PLAY cycles unchanged; without macro pause has no effect.

Source files
------------

// File: rtl/song_memory_reader.sv
// song_memory_reader: plays back note entries stored in the song RAM as timed
// note/octave codes for the buzzer, with a one-hot LED view of the note.
// Each entry is {octave[9:8], note[7:4], dur[3:0]}; dur==0 marks end of song.
// Optional build macro: PLAYER_PAUSE_EN enables the pause/freeze behaviour.
// The FSM state is held in the internal signal `state` for checker binding.
//
// Handshake: start is a one-cycle request honoured only in IDLE (and not
// together with stop); busy rises on the following cycle and stays high until
// playback leaves for DONE/IDLE. stop is a level that aborts from any non-IDLE
// state on the next edge. done is a one-cycle pulse on normal completion only.
module song_memory_reader #(
  parameter int ADDR_W     = 6,
  parameter int TICK_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [1:0]        speed_select,
  input  logic [ADDR_W-1:0] song_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [9:0]        rd_data,
  output logic [3:0]        note_out,
  output logic [1:0]        octave_out,
  output logic [6:0]        led_out,
  output logic              busy,
  output logic              done
);

  // Unit counter must hold the slow-speed unit (TICK_DIV*2) without overflow.
  localparam int UNIT_W = $clog2(TICK_DIV * 2 + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    LOAD  = 3'd3,
    PLAY  = 3'd4,
    GAP   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t            state;
  logic [3:0]        cur_note;
  logic [3:0]        dur_left;
  logic [UNIT_W-1:0] unit_cnt;
  logic [UNIT_W-1:0] unit_len;
  logic [GAP_W-1:0]  gap_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic              run;
  logic [3:0]        ld_note;

  // Cycles per duration unit for the selected playback speed.
  function automatic logic [UNIT_W-1:0] unit_for(input logic [1:0] sel);
    case (sel)
      2'b01:   unit_for = UNIT_W'(TICK_DIV / 2);
      2'b10:   unit_for = UNIT_W'(TICK_DIV * 2);
      default: unit_for = UNIT_W'(TICK_DIV);
    endcase
  endfunction

  // Note codes outside do..si are played as rests.
  function automatic logic [3:0] note_eff(input logic [3:0] n);
    note_eff = (n >= 4'd1 && n <= 4'd7) ? n : 4'd0;
  endfunction

  // One-hot LED pattern, bit n-1 for note n.
  function automatic logic [6:0] note_led(input logic [3:0] n);
    case (n)
      4'd1:    note_led = 7'b0000001;
      4'd2:    note_led = 7'b0000010;
      4'd3:    note_led = 7'b0000100;
      4'd4:    note_led = 7'b0001000;
      4'd5:    note_led = 7'b0010000;
      4'd6:    note_led = 7'b0100000;
      4'd7:    note_led = 7'b1000000;
      default: note_led = 7'b0000000;
    endcase
  endfunction

  assign next_addr = rd_addr + ADDR_W'(1);
  assign ld_note   = note_eff(rd_data[7:4]);

`ifdef PLAYER_PAUSE_EN
  // Pause freezes PLAY/GAP counting; FETCH/WAIT/LOAD never look at it.
  assign run = ~pause;
`else
  // Pause port is accepted but has no effect in this build.
  logic unused_pause;
  assign unused_pause = pause;
  assign run          = 1'b1;
`endif

  // Playback FSM with registered outputs.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      rd_addr    <= '0;
      note_out   <= '0;
      octave_out <= '0;
      led_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_note   <= '0;
      dur_left   <= '0;
      unit_cnt   <= '0;
      unit_len   <= '0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (stop && state != IDLE) begin
        // Abort: silent, not busy, and no done pulse.
        state      <= IDLE;
        busy       <= 1'b0;
        note_out   <= '0;
        led_out    <= '0;
        octave_out <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              rd_addr <= '0;
              if (song_len == '0) begin
                state <= DONE;
                busy  <= 1'b0;
              end else begin
                state <= FETCH;
                busy  <= 1'b1;
              end
            end
          end
          FETCH: state <= WAIT;
          WAIT:  state <= LOAD;
          LOAD: begin
            if (rd_data[3:0] == 4'd0) begin
              // End marker: finish without playing anything.
              state      <= DONE;
              busy       <= 1'b0;
              note_out   <= '0;
              led_out    <= '0;
              octave_out <= '0;
            end else begin
              state      <= PLAY;
              cur_note   <= ld_note;
              note_out   <= ld_note;
              led_out    <= note_led(ld_note);
              octave_out <= rd_data[9:8];
              dur_left   <= rd_data[3:0];
              unit_cnt   <= '0;
              unit_len   <= unit_for(speed_select);
            end
          end
          PLAY: begin
            if (run) begin
              note_out <= cur_note;
              led_out  <= note_led(cur_note);
              if (unit_cnt == unit_len - UNIT_W'(1)) begin
                unit_cnt <= '0;
                if (dur_left == 4'd1) begin
                  state    <= GAP;
                  gap_cnt  <= '0;
                  note_out <= '0;
                  led_out  <= '0;
                end else begin
                  dur_left <= dur_left - 4'd1;
                  unit_len <= unit_for(speed_select);
                end
              end else begin
                unit_cnt <= unit_cnt + UNIT_W'(1);
              end
            end else begin
              note_out <= '0;
              led_out  <= '0;
            end
          end
          GAP: begin
            if (run) begin
              if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                rd_addr <= next_addr;
                if (next_addr == song_len) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  octave_out <= '0;
                end else begin
                  state <= FETCH;
                end
              end else begin
                gap_cnt <= gap_cnt + GAP_W'(1);
              end
            end
          end
          DONE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_memory_reader.sv
// Bench for song_memory_reader with TICK_DIV=4, GAP_CYCLES=2.
// A table of songs is played; for each one a cycle-by-cycle expected trace is
// derived from the song contents and compared sample by sample.
module tb_song_memory_reader;

  localparam int ADDR_W = 6;
  localparam int TICK   = 4;
  localparam int GAPC   = 2;

  logic              clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic [1:0]        speed_select = 2'b00;
  logic [ADDR_W-1:0] song_len = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic [9:0]        rd_data = '0;
  logic [3:0]        note_out;
  logic [1:0]        octave_out;
  logic [6:0]        led_out;
  logic              busy;
  logic              done;

  logic [9:0] mem [64];

  int checks = 0;
  int errors = 0;

  // {busy, done, note, octave, led, addr}
  logic [20:0] exp_q [$];

  typedef struct {
    string          name;
    logic [2:0][9:0] ents;
    int             len;
    logic [1:0]     spd;
    int             exp_done;
  } row_t;

  row_t rows [7];

  song_memory_reader #(
    .ADDR_W(ADDR_W),
    .TICK_DIV(TICK),
    .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk),
    .sys_rst_n(sys_rst_n),
    .start(start),
    .stop(stop),
    .pause(pause),
    .speed_select(speed_select),
    .song_len(song_len),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .note_out(note_out),
    .octave_out(octave_out),
    .led_out(led_out),
    .busy(busy),
    .done(done)
  );

  // Clock and synchronous song RAM model with one-cycle read latency.
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  function automatic logic [9:0] ent(input int oct, input int note, input int dur);
    ent = {2'(oct), 4'(note), 4'(dur)};
  endfunction

  function automatic row_t mk_row(input string name, input logic [9:0] e0,
                                  input logic [9:0] e1, input logic [9:0] e2,
                                  input int len, input logic [1:0] spd,
                                  input int exp_done);
    row_t r;
    r.name = name;
    r.ents[0] = e0;
    r.ents[1] = e1;
    r.ents[2] = e2;
    r.len = len;
    r.spd = spd;
    r.exp_done = exp_done;
    return r;
  endfunction

  function automatic logic [6:0] exp_led(input int n);
    exp_led = (n >= 1 && n <= 7) ? (7'd1 << (n - 1)) : 7'd0;
  endfunction

  function automatic logic [20:0] sample();
    sample = {busy, done, note_out, octave_out, led_out, rd_addr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int b, input int d, input int n, input int o, input int a);
    exp_q.push_back({1'(b), 1'(d), 4'(n), 2'(o), exp_led(n), 6'(a)});
  endtask

  task automatic load_row(input row_t r);
    for (int k = 0; k < 64; k++) mem[k] = '0;
    for (int k = 0; k < 3; k++) mem[k] = r.ents[k];
    song_len = ADDR_W'(r.len);
    speed_select = r.spd;
  endtask

  // Expected per-cycle trace, one entry per sample after the start edge.
  task automatic build_trace(input int len, input int u);
    int addr, oct, n, dur;
    addr = 0;
    oct = 0;
    exp_q.delete();
    if (len != 0) begin
      for (int e = 0; e < 64; e++) begin
        repeat (3) push(1, 0, 0, oct, addr);
        dur = int'(mem[addr][3:0]);
        if (dur == 0) break;
        oct = int'(mem[addr][9:8]);
        n = int'(mem[addr][7:4]);
        if (n > 7) n = 0;
        repeat (dur * u) push(1, 0, n, oct, addr);
        repeat (GAPC) push(1, 0, 0, oct, addr);
        addr = (addr + 1) % 64;
        if (addr == len) break;
      end
    end
    push(0, 0, 0, 0, addr);
    push(0, 1, 0, 0, addr);
    push(0, 0, 0, 0, addr);
  endtask

  task automatic run_trace(input int extra_start_at, input int stop_at, output int done_at);
    logic [20:0] e, a;
    int i;
    done_at = 0;
    i = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() > 0) begin
      i++;
      e = exp_q.pop_front();
      a = sample();
      check($sformatf("trace[%0d]", i), 32'(a), 32'(e));
      if (a[19] && done_at == 0) done_at = i;
      start = (i == extra_start_at);
      if (i == stop_at) begin
        stop = 1'b1;
        exp_q.delete();
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  function automatic int unit_of(input logic [1:0] s);
    case (s)
      2'b01:   unit_of = TICK / 2;
      2'b10:   unit_of = TICK * 2;
      default: unit_of = TICK;
    endcase
  endfunction

  initial begin
    int done_at;

    rows[0] = mk_row("two_notes", ent(1, 3, 2), ent(2, 5, 1), '0, 2, 2'b00, 24);
    rows[1] = mk_row("fast",      ent(1, 4, 2), '0, '0, 1, 2'b01, 11);
    rows[2] = mk_row("slow",      ent(1, 4, 2), '0, '0, 1, 2'b10, 23);
    rows[3] = mk_row("speed_11",  ent(1, 4, 2), '0, '0, 1, 2'b11, 15);
    rows[4] = mk_row("end_mark",  ent(0, 2, 1), ent(3, 6, 0), ent(1, 6, 3), 5, 2'b00, 14);
    rows[5] = mk_row("empty",     ent(1, 3, 2), '0, '0, 0, 2'b00, 2);
    rows[6] = mk_row("rests",     ent(1, 0, 1), ent(2, 9, 1), ent(3, 7, 1), 3, 2'b00, 29);

    for (int k = 0; k < 64; k++) mem[k] = '0;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(sample()), 32'd0);
    sys_rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(sample()), 32'd0);

    // Table-driven songs.
    for (int r = 0; r < 7; r++) begin
      load_row(rows[r]);
      build_trace(rows[r].len, unit_of(rows[r].spd));
      run_trace(0, 0, done_at);
      check({rows[r].name, "_done_cycle"}, 32'(done_at), 32'(rows[r].exp_done));
    end

    // start pulses while busy must not disturb playback.
    load_row(rows[0]);
    build_trace(2, TICK);
    run_trace(10, 0, done_at);
    check("restart_ignored_done", 32'(done_at), 32'd24);

    // Without the pause build, holding pause changes nothing.
`ifndef PLAYER_PAUSE_EN
    pause = 1'b1;
    build_trace(2, TICK);
    run_trace(0, 0, done_at);
    check("pause_ignored_done", 32'(done_at), 32'd24);
    pause = 1'b0;
`endif

    // stop in the middle of the first note.
    build_trace(2, TICK);
    run_trace(0, 6, done_at);
    check("stop_silent", 32'({busy, done, note_out, led_out}), 32'd0);
    stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("stop_no_done[%0d]", k), 32'({busy, done}), 32'd0);
    end

    // start together with stop in IDLE is not accepted.
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("start_stop_idle[%0d]", k), 32'({busy, done, note_out}), 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset during playback clears outputs at once.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_playing", 32'({busy, note_out, octave_out}), 32'({1'b1, 4'd3, 2'd1}));
    sys_rst_n = 1'b0;
    #1;
    check("async_reset", 32'(sample()), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after_reset_quiet", 32'({busy, done}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
